uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte-wide transmit FIFO plus 8-bit UART serializer that consumes the ASCII byte stream (`data_i`/`wr_en`) emitted by the cache-event counter report stage and drives the board's serial TX pin. It absorbs the full report burst, which arrives at one byte per clock, and emits bytes in order as asynchronous serial frames at a fixed baud rate. Default framing is 8N1. An optional even-parity bit can be compiled in.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per serial bit (100 MHz / 115200); legal values ≥ 2.
- `DEPTH`, 32: FIFO entries; power of two, ≥ 4.
- `ADDR_W`, $clog2(DEPTH): pointer width (derived, not overridden).
- `clk`  in  1  sole clock, rising edge.
- `rstn`  in  1  reset, asynchronous assert, active-low.
- `wr_en`  in  1  push `data_i` this cycle.
- `data_i`  in  8  byte to transmit.
- `tx`  out  1  serial line; idle high.
- `full`  out  1  FIFO holds DEPTH bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `level`  out  ADDR_W+1  bytes currently stored, 0..DEPTH.
- `busy`  out  1  serializer not in IDLE.
- `overflow`  out  1  sticky; a write was dropped.

## Operation
- Reset values: `tx`=1, `full`=0, `empty`=1, `level`=0, `busy`=0, `overflow`=0, FSM=IDLE, pointers=0, baud counter=0, bit index=0.
- All status outputs are registered. `full`, `empty` and `level` reflect the state after the previous edge.
- Push: `wr_en && !full` writes `data_i` at the write pointer and increments it, wrapping at DEPTH.
- `wr_en && full`: the byte is dropped and `overflow` is set to 1. This applies even if a pop occurs on the same edge. `overflow` clears only on reset.
- Pop: performed by the FSM only, when `!empty`. It latches the head byte into the shift register and increments the read pointer.
- Simultaneous push and pop (not full, not empty): both happen and `level` is unchanged.
- FSM states:
  - IDLE: `tx`=1. If `!empty`, pop and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: `tx`=shift[0], LSB first, 8 bits of CLKS_PER_BIT cycles each, then PARITY (if enabled) or STOP.
  - PARITY: `tx`=^byte for CLKS_PER_BIT cycles, then STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. On its last cycle, if `!empty`, pop and go to START (no idle gap). Otherwise go to IDLE.
- The baud counter runs 0..CLKS_PER_BIT-1 and resets to 0 on every state/bit change.
- `busy` is 1 in every state except IDLE.
- `tx` is driven from a register: glitch-free and never combinational from the FIFO.

## Timing
- First-byte latency: with the write on edge 0 into an empty FIFO and IDLE, the pop occurs on edge 1 and `tx` falls after edge 2.
- Frame length is 10×CLKS_PER_BIT cycles (11× with parity). Back-to-back frames are contiguous.
- Throughput is one byte per frame time. A burst of ≤ DEPTH+1 bytes at one per cycle is lossless.
- Reset asserted mid-frame: `tx` returns to 1 immediately (asynchronous), FIFO contents are discarded, and the partial frame is abandoned.
- Pointer wrap: DEPTH writes followed by DEPTH reads return the bytes in order across the wrap boundary.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: the PARITY state is present; an even-parity bit (XOR of the 8 data bits) is sent between the last data bit and the stop bit; frame = 11 bits.
  - Undefined: the PARITY state and its logic are absent; frame = 8N1, 10 bits.

## Test plan
- Single byte, CLKS_PER_BIT=4: write 0x61 on edge 0. Required: `tx` low for cycles 3–6, then data bits 1,0,0,0,0,1,1,0 for 4 cycles each, stop high for 4 cycles. `busy` returns to 0 and `empty`=1 at the end.
- Burst, CLKS_PER_BIT=4: 22 consecutive writes of ASCII "a000000b000000c000000" plus one trailing byte. Required: all 22 frames decoded in order, no idle gap between frames, `overflow`=0, peak `level` ≤ 21.
- Overflow, CLKS_PER_BIT=868: 35 consecutive writes of 0x00..0x22. Required: bytes 0x00..0x20 accepted, 0x21 and 0x22 dropped, `overflow`=1, `full`=1, `level`=32 after the last write. Transmitted order is 0x00..0x20.
- Parity, with `UART_TX_PARITY_EN`: send 0x07, then 0x03. Required: parity bit 1 for 0x07 and 0 for 0x03; stop bit starts at bit slot 10.
- Reset mid-frame: assert `rstn`=0 during the DATA state of a frame while 5 bytes are queued. Required: `tx`=1 with no clock edge, `level`=0, `empty`=1, `overflow`=0. After release, the line stays idle until a new write.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte-wide transmit FIFO feeding an 8-bit UART serializer, 8N1 framing by default.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (11-bit frame).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 32,
    parameter int ADDR_W       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [7:0]        data_i,
    output logic              tx,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              busy,
    output logic              overflow
);
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]   LEVEL_MAX = (ADDR_W + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     level_q, level_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                busy_q, busy_d;
    logic                overflow_q, overflow_d;
    logic                tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                par_q, par_d;
`endif
    logic [7:0]          mem_q [DEPTH];
    logic [7:0]          head;
    logic                push, pop, baud_last;

    assign push      = wr_en && !full_q;
    assign head      = mem_q[rd_ptr_q];
    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    state_d = START;
                    baud_d  = '0;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    state_d = STOP;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit so bursts leave no idle gap.
                    if (!empty_q) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            shift_d = head;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head;
`endif
        end
    end

    // The line follows the current state one cycle late, keeping it a clean flop output.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        full_d     = (level_d == LEVEL_MAX);
        empty_d    = (level_d == '0);
        busy_d     = (state_d != IDLE);
        overflow_d = overflow_q | (wr_en & full_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

    assign tx       = tx_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a line decoder rebuilds frames from tx and
// each scenario compares them with the byte stream the FIFO should have accepted.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int CLKS_A = 4;
    localparam int CLKS_B = 868;
    localparam int DEPTH  = 32;
    localparam int AW     = 5;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = FB * CLKS_A;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic wr_a = 1'b0, wr_b = 1'b0;
    logic [7:0] data_a = 8'h00, data_b = 8'h00;
    logic tx_a, full_a, empty_a, busy_a, overflow_a;
    logic tx_b, full_b, empty_b, busy_b, overflow_b;
    logic [AW:0] level_a, level_b;

    int cmp_cnt = 0;
    int fail_cnt = 0;
    int cyc = 0;

    logic [7:0] rx_data[$];
    int         rx_start[$];
    bit         rx_ok[$];
    bit         rx_par[$];
    logic [7:0] exp_q[$];

    uart_tx_fifo #(.CLKS_PER_BIT(CLKS_A), .DEPTH(DEPTH)) dut_a (
        .clk(clk), .rstn(rstn), .wr_en(wr_a), .data_i(data_a), .tx(tx_a),
        .full(full_a), .empty(empty_a), .level(level_a), .busy(busy_a), .overflow(overflow_a)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(CLKS_B), .DEPTH(DEPTH)) dut_b (
        .clk(clk), .rstn(rstn), .wr_en(wr_b), .data_i(data_b), .tx(tx_b),
        .full(full_b), .empty(empty_b), .level(level_b), .busy(busy_b), .overflow(overflow_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Line decoder: every sample of a bit slot must agree; stop slot must be high.
    initial begin : monitor
        logic prev;
        logic [FB-1:0] bits;
        bit ok;
        int st;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && tx_a === 1'b0) begin
                st = cyc;
                ok = 1'b1;
                bits = '0;
                for (int s = 0; s < FB; s++) begin
                    if (s > 0) begin
                        @(negedge clk);
                        bits[s] = tx_a;
                    end
                    for (int c = 1; c < CLKS_A; c++) begin
                        @(negedge clk);
                        if (tx_a !== bits[s]) ok = 1'b0;
                    end
                end
                if (bits[FB-1] !== 1'b1) ok = 1'b0;
                rx_data.push_back(bits[8:1]);
                rx_start.push_back(st);
                rx_ok.push_back(ok);
`ifdef UART_TX_PARITY_EN
                rx_par.push_back(bits[9]);
`endif
                prev = 1'b1;
            end else begin
                prev = tx_a;
            end
        end
    end

    task automatic clear_rx();
        rx_data.delete();
        rx_start.delete();
        rx_ok.delete();
        rx_par.delete();
        exp_q.delete();
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int b;
        b = budget;
        while (rx_data.size() < n && b > 0) begin
            @(negedge clk);
            b--;
        end
        cmp_cnt++;
        if (rx_data.size() < n) begin
            fail_cnt++;
            $display("FAIL %s_timeout: frames seen %0d, required %0d", name, rx_data.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int b;
        b = budget;
        while (!(busy_a === 1'b0 && empty_a === 1'b1) && b > 0) begin
            @(negedge clk);
            b--;
        end
        cmp_cnt++;
        if (b == 0) begin
            fail_cnt++;
            $display("FAIL %s_idle_timeout: busy=%b empty=%b, required busy=0 empty=1", name, busy_a, empty_a);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        cmp_cnt++; if (tx_a !== 1'b1) begin fail_cnt++; $display("FAIL reset_tx: got %b, required 1", tx_a); end
        cmp_cnt++; if (full_a !== 1'b0) begin fail_cnt++; $display("FAIL reset_full: got %b, required 0", full_a); end
        cmp_cnt++; if (empty_a !== 1'b1) begin fail_cnt++; $display("FAIL reset_empty: got %b, required 1", empty_a); end
        cmp_cnt++; if (level_a !== 6'd0) begin fail_cnt++; $display("FAIL reset_level: got %0d, required 0", level_a); end
        cmp_cnt++; if (busy_a !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy: got %b, required 0", busy_a); end
        cmp_cnt++; if (overflow_a !== 1'b0) begin fail_cnt++; $display("FAIL reset_overflow: got %b, required 0", overflow_a); end
        cmp_cnt++; if (tx_b !== 1'b1 || empty_b !== 1'b1) begin fail_cnt++; $display("FAIL reset_b: tx=%b empty=%b, required 1 1", tx_b, empty_b); end
    endtask

    task automatic test_single_byte();
        int e0;
        clear_rx();
        @(negedge clk); wr_a = 1'b1; data_a = 8'h61;
        @(negedge clk); wr_a = 1'b0; e0 = cyc;
        cmp_cnt++; if (empty_a !== 1'b0 || level_a !== 6'd1) begin fail_cnt++; $display("FAIL single_after_write: empty=%b level=%0d, required 0 1", empty_a, level_a); end
        @(negedge clk);
        cmp_cnt++; if (busy_a !== 1'b1 || empty_a !== 1'b1) begin fail_cnt++; $display("FAIL single_pop: busy=%b empty=%b, required 1 1", busy_a, empty_a); end
        wait_frames(1, FRAME + 20, "single");
        if (rx_data.size() >= 1) begin
            cmp_cnt++; if (rx_start[0] !== e0 + 2) begin fail_cnt++; $display("FAIL single_latency: tx fell after edge %0d, required %0d", rx_start[0], e0 + 2); end
            cmp_cnt++; if (rx_data[0] !== 8'h61) begin fail_cnt++; $display("FAIL single_data: got %h, required 61", rx_data[0]); end
            cmp_cnt++; if (rx_ok[0] !== 1'b1) begin fail_cnt++; $display("FAIL single_framing: got %b, required 1", rx_ok[0]); end
        end
        @(negedge clk);
        cmp_cnt++; if (busy_a !== 1'b0 || empty_a !== 1'b1 || tx_a !== 1'b1) begin fail_cnt++; $display("FAIL single_end: busy=%b empty=%b tx=%b, required 0 1 1", busy_a, empty_a, tx_a); end
    endtask

    task automatic test_burst();
        string s;
        int e0, peak, exp_lvl;
        clear_rx();
        s = "a000000b000000c000000";
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0A);
        peak = 0; e0 = 0;
        for (int k = 0; k <= 22; k++) begin
            @(negedge clk);
            if (k == 1) e0 = cyc;
            if (k > 0) begin
                exp_lvl = (k == 1) ? 1 : k - 1;
                if (int'(level_a) > peak) peak = int'(level_a);
                cmp_cnt++; if (level_a !== 6'(exp_lvl)) begin fail_cnt++; $display("FAIL burst_level_%0d: got %0d, required %0d", k, level_a, exp_lvl); end
            end
            if (k < 22) begin wr_a = 1'b1; data_a = exp_q[k]; end
            else wr_a = 1'b0;
        end
        cmp_cnt++; if (peak > 21) begin fail_cnt++; $display("FAIL burst_peak: got %0d, required <= 21", peak); end
        wait_frames(22, 22 * FRAME + 50, "burst");
        for (int i = 0; i < 22 && i < rx_data.size(); i++) begin
            cmp_cnt++;
            if (rx_data[i] !== exp_q[i] || rx_ok[i] !== 1'b1) begin
                fail_cnt++; $display("FAIL burst_frame_%0d: got %h ok=%b, required %h ok=1", i, rx_data[i], rx_ok[i], exp_q[i]);
            end
            cmp_cnt++;
            if (rx_start[i] !== ((i == 0) ? e0 + 2 : rx_start[i-1] + FRAME)) begin
                fail_cnt++; $display("FAIL burst_spacing_%0d: start %0d, required %0d", i, rx_start[i], (i == 0) ? e0 + 2 : rx_start[i-1] + FRAME);
            end
        end
        cmp_cnt++; if (overflow_a !== 1'b0) begin fail_cnt++; $display("FAIL burst_overflow: got %b, required 0", overflow_a); end
        wait_idle(200, "burst");
    endtask

    task automatic test_random_bursts();
        int len;
        for (int it = 0; it < 4; it++) begin
            clear_rx();
            len = (it == 0) ? DEPTH + 1 : $urandom_range(DEPTH + 1, 1);
            for (int k = 0; k < len; k++) begin
                exp_q.push_back(8'($urandom));
                @(negedge clk); wr_a = 1'b1; data_a = exp_q[k];
                if (it > 0) begin
                    @(negedge clk); wr_a = 1'b0;
                    repeat ($urandom_range(1, 0)) @(negedge clk);
                end
            end
            @(negedge clk); wr_a = 1'b0;
            wait_frames(len, len * FRAME + 200, "random");
            repeat (FRAME) @(negedge clk);
            cmp_cnt++; if (rx_data.size() != len) begin fail_cnt++; $display("FAIL random_count_%0d: got %0d, required %0d", it, rx_data.size(), len); end
            for (int i = 0; i < len && i < rx_data.size(); i++) begin
                cmp_cnt++;
                if (rx_data[i] !== exp_q[i] || rx_ok[i] !== 1'b1) begin
                    fail_cnt++; $display("FAIL random_%0d_frame_%0d: got %h ok=%b, required %h", it, i, rx_data[i], rx_ok[i], exp_q[i]);
                end
            end
            cmp_cnt++; if (overflow_a !== 1'b0) begin fail_cnt++; $display("FAIL random_overflow_%0d: got %b, required 0", it, overflow_a); end
            wait_idle(200, "random");
        end
    endtask

    task automatic test_overflow();
        clear_rx();
        for (int k = 0; k < 35; k++) begin
            @(negedge clk);
            if (k == 33) begin
                cmp_cnt++; if (full_a !== 1'b1 || overflow_a !== 1'b0) begin fail_cnt++; $display("FAIL ovf_at_full: full=%b overflow=%b, required 1 0", full_a, overflow_a); end
            end
            wr_a = 1'b1; data_a = 8'(k);
            wr_b = 1'b1; data_b = 8'(k);
            if (k <= DEPTH) exp_q.push_back(8'(k));
        end
        @(negedge clk); wr_a = 1'b0; wr_b = 1'b0;
        cmp_cnt++; if (level_a !== 6'd32 || full_a !== 1'b1 || overflow_a !== 1'b1) begin fail_cnt++; $display("FAIL ovf_a_status: level=%0d full=%b ovf=%b, required 32 1 1", level_a, full_a, overflow_a); end
        cmp_cnt++; if (level_b !== 6'd32 || full_b !== 1'b1 || overflow_b !== 1'b1) begin fail_cnt++; $display("FAIL ovf_b_status: level=%0d full=%b ovf=%b, required 32 1 1", level_b, full_b, overflow_b); end
        wait_frames(DEPTH + 1, (DEPTH + 1) * FRAME + 100, "ovf");
        repeat (2 * FRAME) @(negedge clk);
        cmp_cnt++; if (rx_data.size() != DEPTH + 1) begin fail_cnt++; $display("FAIL ovf_count: got %0d, required %0d", rx_data.size(), DEPTH + 1); end
        for (int i = 0; i < DEPTH + 1 && i < rx_data.size(); i++) begin
            cmp_cnt++;
            if (rx_data[i] !== exp_q[i] || rx_ok[i] !== 1'b1) begin
                fail_cnt++; $display("FAIL ovf_frame_%0d: got %h ok=%b, required %h", i, rx_data[i], rx_ok[i], exp_q[i]);
            end
        end
        cmp_cnt++; if (overflow_a !== 1'b1 || empty_a !== 1'b1) begin fail_cnt++; $display("FAIL ovf_sticky: overflow=%b empty=%b, required 1 1", overflow_a, empty_a); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        clear_rx();
        @(negedge clk); wr_a = 1'b1; data_a = 8'h07;
        @(negedge clk); data_a = 8'h03;
        @(negedge clk); wr_a = 1'b0;
        wait_frames(2, 2 * FRAME + 50, "parity");
        if (rx_data.size() >= 2) begin
            cmp_cnt++; if (rx_data[0] !== 8'h07 || rx_par[0] !== 1'b1 || rx_ok[0] !== 1'b1) begin fail_cnt++; $display("FAIL parity_07: data=%h par=%b ok=%b, required 07 1 1", rx_data[0], rx_par[0], rx_ok[0]); end
            cmp_cnt++; if (rx_data[1] !== 8'h03 || rx_par[1] !== 1'b0 || rx_ok[1] !== 1'b1) begin fail_cnt++; $display("FAIL parity_03: data=%h par=%b ok=%b, required 03 0 1", rx_data[1], rx_par[1], rx_ok[1]); end
            cmp_cnt++; if (rx_start[1] - rx_start[0] !== 11 * CLKS_A) begin fail_cnt++; $display("FAIL parity_frame_len: got %0d, required %0d", rx_start[1] - rx_start[0], 11 * CLKS_A); end
        end
        wait_idle(200, "parity");
    endtask
`endif

    task automatic test_reset_mid_frame();
        int e0, lows, b;
        clear_rx();
        e0 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 1) e0 = cyc;
            wr_a = 1'b1; data_a = 8'hA0 + 8'(k);
        end
        @(negedge clk); wr_a = 1'b0;
        b = 200;
        while (cyc < e0 + 2 + CLKS_A + 5 && b > 0) begin @(negedge clk); b--; end
        cmp_cnt++; if (level_a !== 6'd5 || busy_a !== 1'b1) begin fail_cnt++; $display("FAIL midrst_pre: level=%0d busy=%b, required 5 1", level_a, busy_a); end
        #2 rstn = 1'b0;
        #1;
        cmp_cnt++; if (tx_a !== 1'b1 || level_a !== 6'd0 || empty_a !== 1'b1) begin fail_cnt++; $display("FAIL midrst_async: tx=%b level=%0d empty=%b, required 1 0 1", tx_a, level_a, empty_a); end
        cmp_cnt++; if (overflow_a !== 1'b0 || busy_a !== 1'b0 || full_a !== 1'b0) begin fail_cnt++; $display("FAIL midrst_flags: ovf=%b busy=%b full=%b, required 0 0 0", overflow_a, busy_a, full_a); end
        cmp_cnt++; if (tx_b !== 1'b1 || level_b !== 6'd0 || overflow_b !== 1'b0) begin fail_cnt++; $display("FAIL midrst_b: tx=%b level=%0d ovf=%b, required 1 0 0", tx_b, level_b, overflow_b); end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (FRAME + 10) @(negedge clk);
        clear_rx();
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1) lows++;
        end
        cmp_cnt++; if (lows != 0 || rx_data.size() != 0) begin fail_cnt++; $display("FAIL midrst_idle: low samples=%0d frames=%0d, required 0 0", lows, rx_data.size()); end
        cmp_cnt++; if (level_a !== 6'd0 || empty_a !== 1'b1) begin fail_cnt++; $display("FAIL midrst_level: level=%0d empty=%b, required 0 1", level_a, empty_a); end
        @(negedge clk); wr_a = 1'b1; data_a = 8'h5A;
        @(negedge clk); wr_a = 1'b0;
        wait_frames(1, FRAME + 20, "midrst_new");
        if (rx_data.size() >= 1) begin
            cmp_cnt++; if (rx_data[0] !== 8'h5A || rx_ok[0] !== 1'b1) begin fail_cnt++; $display("FAIL midrst_new_byte: got %h ok=%b, required 5A 1", rx_data[0], rx_ok[0]); end
        end
        wait_idle(200, "midrst");
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst();
        test_random_bursts();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_overflow();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end
endmodule
